// File: rtl/fmc_slave_bridge_if.sv
// Signal bundle between the ARM FMC pads / register bank and the bridge.
// The bridge uses the slave view; the pad/bank side uses the master view.
`timescale 1ns/1ps
interface fmc_slave_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              arm_ncs;
    logic              arm_nwe;
    logic              arm_noe;
    logic [ADDR_W-1:0] arm_addr;
    logic [DATA_W-1:0] arm_din;
    logic [DATA_W-1:0] arm_dout;
    logic              arm_doe;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport slave (
        input  arm_ncs, arm_nwe, arm_noe, arm_addr, arm_din, rd_data,
        output arm_dout, arm_doe, wr_en, wr_addr, wr_data, rd_req, rd_addr, busy
    );

    modport master (
        output arm_ncs, arm_nwe, arm_noe, arm_addr, arm_din, rd_data,
        input  arm_dout, arm_doe, wr_en, wr_addr, wr_data, rd_req, rd_addr, busy
    );
endinterface

// File: rtl/fmc_slave_bridge.sv
// ARM asynchronous FMC responder: synchronises the bus, turns writes into
// one-cycle register strobes and reads into bank requests driven back to the pad.
`timescale 1ns/1ps
module fmc_slave_bridge #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic clk,
    input  logic rst,
    fmc_slave_bridge_if.slave bus
);
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE, WR_ACT, RD_REQ, RD_WAIT, RD_DRIVE, WAIT_CS
    } state_e;

    // Strobes, address and data share the same depth so they stay aligned.
    logic [SYNC_STAGES-1:0]             ncs_sync_q, nwe_sync_q, noe_sync_q;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] addr_sync_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] din_sync_q;

    logic              s_ncs, s_nwe, s_noe;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_din;

    assign s_ncs  = ncs_sync_q[SYNC_STAGES-1];
    assign s_nwe  = nwe_sync_q[SYNC_STAGES-1];
    assign s_noe  = noe_sync_q[SYNC_STAGES-1];
    assign s_addr = addr_sync_q[SYNC_STAGES-1];
    assign s_din  = din_sync_q[SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_pend_q, wr_pend_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doe_q, doe_d;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_pend_d = 1'b0;
        wr_en_d   = wr_pend_q;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        doe_d     = doe_q;
        case (state_q)
            IDLE: begin
                if (!s_ncs && !s_nwe) begin
                    state_d   = WR_ACT;
                    wr_addr_d = s_addr;
                    wr_data_d = s_din;
                end else if (!s_ncs && !s_noe) begin
                    state_d   = RD_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = s_addr;
                end
            end
            WR_ACT: begin
                // Keep sampling while nWE is low; the sample that sees nWE high is past the edge.
                if (s_ncs) begin
                    state_d = IDLE;
                end else if (s_nwe) begin
                    state_d   = WAIT_CS;
                    wr_pend_d = 1'b1;
                end else begin
                    wr_addr_d = s_addr;
                    wr_data_d = s_din;
                end
            end
            RD_REQ: begin
                if (s_ncs || s_noe) begin
                    state_d = WAIT_CS;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RD_WAIT: begin
                if (s_ncs || s_noe) begin
                    state_d = WAIT_CS;
                end else if (cnt_q == CNT_W'(RD_LATENCY)) begin
                    state_d = RD_DRIVE;
                    dout_d  = bus.rd_data;
                    doe_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_DRIVE: begin
                if (s_ncs || s_noe) begin
                    state_d = WAIT_CS;
                    doe_d   = 1'b0;
                end
            end
            WAIT_CS: begin
                if (s_ncs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync_q  <= '1;
            nwe_sync_q  <= '1;
            noe_sync_q  <= '1;
            addr_sync_q <= '0;
            din_sync_q  <= '0;
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.arm_ncs};
            nwe_sync_q  <= {nwe_sync_q[SYNC_STAGES-2:0], bus.arm_nwe};
            noe_sync_q  <= {noe_sync_q[SYNC_STAGES-2:0], bus.arm_noe};
            addr_sync_q <= {addr_sync_q[SYNC_STAGES-2:0], bus.arm_addr};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.arm_din};
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_pend_q   <= wr_pend_d;
            wr_en_q     <= wr_en_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.arm_dout = dout_q;
    assign bus.arm_doe  = doe_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_fmc_slave_bridge.sv
// Bench for fmc_slave_bridge: ARM bus-cycle tasks, a register bank model,
// and scoreboards for write strobes and read requests.
`timescale 1ns/1ps
module tb_fmc_slave_bridge;
    localparam int S = 2;
    localparam int L = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmc_slave_bridge_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    fmc_slave_bridge #(.ADDR_W(12), .DATA_W(8), .SYNC_STAGES(S), .RD_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;
    typedef struct { bit rd; logic [11:0] a; logic [7:0] d; } vec_t;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, rd_cnt = 0, doe_cnt = 0;
    wr_t         wq[$];
    logic [11:0] rq[$];
    logic [7:0]  mem [0:4095];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank: one-cycle read latency, 0x204 hard-wired to 0xA5.
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_req) bus.rd_data <= (bus.rd_addr == 12'h204) ? 8'hA5 : mem[bus.rd_addr];
    end

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got addr=%0h data=%0h want none", bus.wr_addr, bus.wr_data);
                end else begin
                    e = wq.pop_front();
                    chk("wr_sb", {bus.wr_addr, bus.wr_data}, e);
                end
            end
            if (bus.rd_req) begin
                rd_cnt++;
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got addr=%0h want none", bus.rd_addr);
                end else begin
                    chk("rd_sb", bus.rd_addr, rq.pop_front());
                end
            end
            if (bus.arm_doe) doe_cnt++;
        end
    end

    task automatic wr_cycle(input logic [11:0] a, input logic [7:0] d);
        wq.push_back({a, d});
        bus.arm_ncs = 1'b0; bus.arm_addr = a; bus.arm_din = d;
        #62.5 bus.arm_nwe = 1'b0;
        #40   bus.arm_nwe = 1'b1;
        #22.5 bus.arm_ncs = 1'b1;
        #40;
    endtask

    task automatic rd_cycle(input logic [11:0] a, input logic [7:0] exp);
        int n;
        rq.push_back(a);
        bus.arm_ncs = 1'b0; bus.arm_addr = a;
        #20;
        @(negedge clk); #1 bus.arm_noe = 1'b0;
        n = 0;
        while (!bus.arm_doe && n < 20) begin @(posedge clk); #1; n++; end
        chk("rd_lat", n, S + 2 + L);
        chk("rd_dout", {bus.arm_doe, bus.arm_dout}, {1'b1, exp});
        repeat (4) @(negedge clk);
        chk("rd_hold", {bus.arm_doe, bus.arm_dout, bus.rd_addr}, {1'b1, exp, a});
        @(negedge clk); #1 bus.arm_noe = 1'b1;
        n = 0;
        while (bus.arm_doe && n < 20) begin @(posedge clk); #1; n++; end
        chk("rd_drop", (n <= S + 1) && !bus.arm_doe, 1'b1);
        #20 bus.arm_ncs = 1'b1;
        #40;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [47:0] pat;
        logic [7:0]  pb;
        int n, c0, c1, c2;

        pat = 48'd9007199254740;
        for (int i = 0; i < 6; i++) begin
            pb = pat[8*i +: 8];
            tbl.push_back('{1'b0, 12'(12'h003 + i), pb});
        end
        for (int i = 0; i < 6; i++) begin
            pb = pat[8*i +: 8];
            tbl.push_back('{1'b0, 12'(12'h103 + i), pb});
        end
        tbl.push_back('{1'b1, 12'h204, 8'hA5});
        tbl.push_back('{1'b1, 12'h02D, 8'h0F});
        tbl.push_back('{1'b1, 12'h105, 8'hE9});
        tbl.push_back('{1'b1, 12'h008, 8'h08});

        rst = 1'b1;
        bus.arm_ncs = 1'b1; bus.arm_nwe = 1'b1; bus.arm_noe = 1'b1;
        bus.arm_addr = '0; bus.arm_din = '0;
        #23;
        chk("reset_outs", {bus.wr_en, bus.rd_req, bus.arm_doe, bus.busy, bus.wr_addr,
                           bus.wr_data, bus.rd_addr, bus.arm_dout}, 64'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single write with latency check on the nWE rising edge.
        wq.push_back({12'h02D, 8'h0F});
        bus.arm_ncs = 1'b0; bus.arm_addr = 12'h02D; bus.arm_din = 8'h0F;
        #62.5;
        @(negedge clk); #1 bus.arm_nwe = 1'b0;
        #40 bus.arm_nwe = 1'b1;
        fork #22.5 bus.arm_ncs = 1'b1; join_none
        n = 0;
        while (!bus.wr_en && n < 20) begin @(posedge clk); #1; n++; end
        chk("wr_lat", n, S + 2);
        #60;
        chk("wr_first_cnt", {wr_cnt, rd_cnt}, {32'd1, 32'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rd) rd_cycle(tbl[i].a, tbl[i].d);
            else           wr_cycle(tbl[i].a, tbl[i].d);
        end
        chk("table_counts", {wr_cnt, rd_cnt}, {32'd13, 32'd4});

        // nCS rises while nWE still low: aborted write.
        c0 = wr_cnt;
        bus.arm_ncs = 1'b0; bus.arm_addr = 12'h077; bus.arm_din = 8'h99;
        #30 bus.arm_nwe = 1'b0;
        #40 bus.arm_ncs = 1'b1;
        #20 bus.arm_nwe = 1'b1;
        #80;
        chk("abort_no_wr", wr_cnt - c0, 0);
        chk("abort_idle", bus.busy, 1'b0);

        // Both strobes low together: write wins, no read side effects.
        c0 = wr_cnt; c1 = rd_cnt; c2 = doe_cnt;
        wq.push_back({12'h0AB, 8'h5C});
        bus.arm_ncs = 1'b0; bus.arm_addr = 12'h0AB; bus.arm_din = 8'h5C;
        #62.5 begin bus.arm_nwe = 1'b0; bus.arm_noe = 1'b0; end
        #40 bus.arm_nwe = 1'b1;
        #22.5 begin bus.arm_ncs = 1'b1; bus.arm_noe = 1'b1; end
        #80;
        chk("both_one_wr", wr_cnt - c0, 1);
        chk("both_no_rd", {rd_cnt - c1, doe_cnt - c2}, 64'd0);

        // Reset pulsed while the bridge drives read data.
        rq.push_back(12'h204);
        bus.arm_ncs = 1'b0; bus.arm_addr = 12'h204;
        #20 bus.arm_noe = 1'b0;
        n = 0;
        while (!bus.arm_doe && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst_pre_doe", bus.arm_doe, 1'b1);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", {bus.wr_en, bus.rd_req, bus.arm_doe, bus.busy, bus.wr_addr,
                             bus.wr_data, bus.rd_addr, bus.arm_dout}, 64'd0);
        bus.arm_noe = 1'b1; bus.arm_ncs = 1'b1;
        #30;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        c0 = wr_cnt;
        wr_cycle(12'h12D, 8'h0F);
        #40;
        chk("post_rst_wr", wr_cnt - c0, 1);
        rd_cycle(12'h12D, 8'h0F);

        repeat (10) @(negedge clk);
        chk("sb_empty", {wq.size(), rq.size()}, 64'd0);
        chk("final_idle", {bus.busy, bus.arm_doe}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
